// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
//
// eUSCI_A UART receive buffer and interrupt controller. Captures completed
// frames from the receive state machine into RXBUF, accumulates sticky
// receive error status for STATW, owns the IFG/IE flag registers and resolves
// them into a registered, prioritised interrupt vector (IV) plus a single
// combinational interrupt request (IRQ).
//
// Ports
//   MCLK          in   1   system clock, all state changes on posedge
//   reset         in   1   asynchronous, active-high reset
//   wUCSWRST      in   1   software reset level, synchronous clear while high
//   rSetRxIFG     in   1   frame accepted pulse (loads RXBUF, sets RX flag)
//   RxData        in   8   received character, valid with rSetRxIFG
//   rUCPE/FE/OE/BRK in 1   error pulses at frame completion
//   RxBusy/TxBusy in   1   engine busy levels
//   setTxIFG, setSttIFG, setTxCptIFG  in 1  flag set pulses from transmit side
//   rdRXBUF       in   1   bus read strobe of RXBUF
//   rdIV          in   1   bus read strobe of IV
//   wrIFG, wrIE   in   1   bus write strobes for IFG / IE
//   wData         in   4   IFG/IE write data {TXCPT, STT, TX, RX}
//   RXBUF         out  8   received-data register
//   STATW         out  8   {0, FE, OE, PE, BRK, RXERR, 0, BUSY}
//   IFG           out  4   interrupt flags {TXCPT, STT, TX, RX}
//   IE            out  4   interrupt enables, same order
//   IV            out 16   registered interrupt vector
//   RxIFG         out  1   IFG[0], fed back for upstream overrun detection
//   IRQ           out  1   |(IFG & IE)
// -----------------------------------------------------------------------------
module uart_rx_ctrl (
    input  logic        MCLK,
    input  logic        reset,
    input  logic        wUCSWRST,
    input  logic        rSetRxIFG,
    input  logic [7:0]  RxData,
    input  logic        rUCPE,
    input  logic        rUCFE,
    input  logic        rUCOE,
    input  logic        rUCBRK,
    input  logic        RxBusy,
    input  logic        TxBusy,
    input  logic        setTxIFG,
    input  logic        setSttIFG,
    input  logic        setTxCptIFG,
    input  logic        rdRXBUF,
    input  logic        rdIV,
    input  logic        wrIFG,
    input  logic        wrIE,
    input  logic [3:0]  wData,
    output logic [7:0]  RXBUF,
    output logic [7:0]  STATW,
    output logic [3:0]  IFG,
    output logic [3:0]  IE,
    output logic [15:0] IV,
    output logic        RxIFG,
    output logic        IRQ
);

    localparam logic [3:0] IFG_RESET = 4'b0010;  // TX buffer starts empty

    // Sticky receive error bits
    logic fe, oe, pe, brk;

    // Next-state values for every register
    logic [3:0]  set_flags;
    logic [3:0]  clr_flags;
    logic [3:0]  ifg_next;
    logic [3:0]  ie_next;
    logic [15:0] iv_next;
    logic        fe_next, oe_next, pe_next, brk_next;

    // Highest-priority pending source: RX, TX, STT, TXCPT.
    function automatic logic [15:0] iv_encode(input logic [3:0] pend);
        if (pend[0])      return 16'h0002;
        else if (pend[1]) return 16'h0004;
        else if (pend[2]) return 16'h0006;
        else if (pend[3]) return 16'h0008;
        else              return 16'h0000;
    endfunction

    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        set_flags = {setTxCptIFG, setSttIFG, setTxIFG, rSetRxIFG};
        clr_flags = 4'b0000;

        // An IV read acknowledges only the source the vector currently names,
        // so back-to-back reads drain sources in priority order.
        if (rdIV) begin
            case (IV)
                16'h0002: clr_flags[0] = 1'b1;
                16'h0004: clr_flags[1] = 1'b1;
                16'h0006: clr_flags[2] = 1'b1;
                16'h0008: clr_flags[3] = 1'b1;
                default:  clr_flags    = 4'b0000;
            endcase
        end
        if (rdRXBUF) begin
            clr_flags[0] = 1'b1;
        end

        // Precedence low to high: clear, bus write, set pulse, software reset.
        ifg_next = wrIFG ? wData : (IFG & ~clr_flags);
        ifg_next = ifg_next | set_flags;
        if (wUCSWRST) begin
            ifg_next = IFG_RESET;
        end

        ie_next = wrIE ? wData : IE;

        // Errors of the current frame survive a same-cycle RXBUF read; only
        // the previously accumulated status is cleared by it.
        fe_next  = (fe  & ~rdRXBUF) | rUCFE;
        oe_next  = (oe  & ~rdRXBUF) | rUCOE;
        pe_next  = (pe  & ~rdRXBUF) | rUCPE;
        brk_next = (brk & ~rdRXBUF) | rUCBRK;
        if (wUCSWRST) begin
            fe_next  = 1'b0;
            oe_next  = 1'b0;
            pe_next  = 1'b0;
            brk_next = 1'b0;
        end

        // IV is built from the post-edge flags so it never names a source
        // that the same edge has just acknowledged.
        iv_next = iv_encode(ifg_next & ie_next);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            RXBUF <= 8'h00;
            IFG   <= IFG_RESET;
            IE    <= 4'b0000;
            IV    <= 16'h0000;
            fe    <= 1'b0;
            oe    <= 1'b0;
            pe    <= 1'b0;
            brk   <= 1'b0;
        end else begin
            if (rSetRxIFG && !wUCSWRST) begin
                RXBUF <= RxData;
            end
            IFG <= ifg_next;
            IE  <= ie_next;
            IV  <= iv_next;
            fe  <= fe_next;
            oe  <= oe_next;
            pe  <= pe_next;
            brk <= brk_next;
        end
    end

    assign STATW = {1'b0, fe, oe, pe, brk, (fe | oe | pe), 1'b0, (RxBusy | TxBusy)};
    assign RxIFG = IFG[0];
    assign IRQ   = |(IFG & IE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_ctrl
//
// Self-checking bench for uart_rx_ctrl. A table of one-cycle vectors (inputs
// plus the register values expected after that edge) is applied in order;
// each vector's expectation is queued when it is driven and popped when the
// DUT outputs are sampled. Asynchronous reset is exercised by a hand-written
// sequence at the end.
// -----------------------------------------------------------------------------
module tb_uart_rx_ctrl;

    logic        MCLK = 1'b0;
    logic        reset;
    logic        wUCSWRST, rSetRxIFG;
    logic [7:0]  RxData;
    logic        rUCPE, rUCFE, rUCOE, rUCBRK;
    logic        RxBusy, TxBusy;
    logic        setTxIFG, setSttIFG, setTxCptIFG;
    logic        rdRXBUF, rdIV, wrIFG, wrIE;
    logic [3:0]  wData;
    logic [7:0]  RXBUF, STATW;
    logic [3:0]  IFG, IE;
    logic [15:0] IV;
    logic        RxIFG, IRQ;

    int checks = 0;
    int errors = 0;

    uart_rx_ctrl dut (
        .MCLK(MCLK), .reset(reset), .wUCSWRST(wUCSWRST), .rSetRxIFG(rSetRxIFG),
        .RxData(RxData), .rUCPE(rUCPE), .rUCFE(rUCFE), .rUCOE(rUCOE),
        .rUCBRK(rUCBRK), .RxBusy(RxBusy), .TxBusy(TxBusy), .setTxIFG(setTxIFG),
        .setSttIFG(setSttIFG), .setTxCptIFG(setTxCptIFG), .rdRXBUF(rdRXBUF),
        .rdIV(rdIV), .wrIFG(wrIFG), .wrIE(wrIE), .wData(wData), .RXBUF(RXBUF),
        .STATW(STATW), .IFG(IFG), .IE(IE), .IV(IV), .RxIFG(RxIFG), .IRQ(IRQ)
    );

    always #5 MCLK = ~MCLK;

    // ctl = {swrst, rd_rxbuf, rd_iv, set_rx}; err = {fe, oe, pe, brk};
    // txs = {txcpt, stt, tx}; wr = {wr_ifg, wr_ie}; busy = {rx, tx}
    typedef struct {
        logic [3:0]  ctl;
        logic [3:0]  err;
        logic [2:0]  txs;
        logic [1:0]  wr;
        logic [3:0]  wd;
        logic [7:0]  rxd;
        logic [1:0]  busy;
        logic [7:0]  e_rxbuf;
        logic [7:0]  e_statw;
        logic [3:0]  e_ifg;
        logic [3:0]  e_ie;
        logic [15:0] e_iv;
        logic        e_irq;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    function automatic vec_t mk(
        input logic [3:0] ctl, input logic [3:0] err, input logic [2:0] txs,
        input logic [1:0] wr, input logic [3:0] wd, input logic [7:0] rxd,
        input logic [1:0] busy, input logic [7:0] e_rxbuf, input logic [7:0] e_statw,
        input logic [3:0] e_ifg, input logic [3:0] e_ie, input logic [15:0] e_iv,
        input logic e_irq);
        vec_t v;
        v.ctl = ctl; v.err = err; v.txs = txs; v.wr = wr; v.wd = wd;
        v.rxd = rxd; v.busy = busy; v.e_rxbuf = e_rxbuf; v.e_statw = e_statw;
        v.e_ifg = e_ifg; v.e_ie = e_ie; v.e_iv = e_iv; v.e_irq = e_irq;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        wUCSWRST = 0; rSetRxIFG = 0; RxData = 8'h00;
        rUCPE = 0; rUCFE = 0; rUCOE = 0; rUCBRK = 0;
        RxBusy = 0; TxBusy = 0;
        setTxIFG = 0; setSttIFG = 0; setTxCptIFG = 0;
        rdRXBUF = 0; rdIV = 0; wrIFG = 0; wrIE = 0; wData = 4'h0;
    endtask

    task automatic drive(input vec_t v);
        {wUCSWRST, rdRXBUF, rdIV, rSetRxIFG} = v.ctl;
        {rUCFE, rUCOE, rUCPE, rUCBRK}        = v.err;
        {setTxCptIFG, setSttIFG, setTxIFG}   = v.txs;
        {wrIFG, wrIE}                        = v.wr;
        {RxBusy, TxBusy}                     = v.busy;
        wData  = v.wd;
        RxData = v.rxd;
    endtask

    task automatic compare(input string tag, input vec_t v);
        check({tag, " RXBUF"}, 16'(RXBUF), 16'(v.e_rxbuf));
        check({tag, " STATW"}, 16'(STATW), 16'(v.e_statw));
        check({tag, " IFG"},   16'(IFG),   16'(v.e_ifg));
        check({tag, " IE"},    16'(IE),    16'(v.e_ie));
        check({tag, " IV"},    IV,         v.e_iv);
        check({tag, " IRQ"},   16'(IRQ),   16'(v.e_irq));
        check({tag, " RxIFG"}, 16'(RxIFG), 16'(v.e_ifg[0]));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        //            ctl      err      txs     wr     wd    rxd    busy    rxbuf  statw  ifg   ie    iv        irq
        // capture
        vecs.push_back(mk(4'b0000, 4'b0000, 3'b000, 2'b01, 4'h1, 8'h00, 2'b00, 8'h00, 8'h00, 4'h2, 4'h1, 16'h0000, 1'b0));
        vecs.push_back(mk(4'b0001, 4'b0000, 3'b000, 2'b00, 4'h0, 8'hA5, 2'b00, 8'hA5, 8'h00, 4'h3, 4'h1, 16'h0002, 1'b1));
        vecs.push_back(mk(4'b0100, 4'b0000, 3'b000, 2'b00, 4'h0, 8'h00, 2'b00, 8'hA5, 8'h00, 4'h2, 4'h1, 16'h0000, 1'b0));
        // errors: rejected frame, then BRK frame, then read clears
        vecs.push_back(mk(4'b0000, 4'b1000, 3'b000, 2'b00, 4'h0, 8'h77, 2'b00, 8'hA5, 8'h44, 4'h2, 4'h1, 16'h0000, 1'b0));
        vecs.push_back(mk(4'b0001, 4'b0001, 3'b000, 2'b00, 4'h0, 8'h00, 2'b00, 8'h00, 8'h4C, 4'h3, 4'h1, 16'h0002, 1'b1));
        vecs.push_back(mk(4'b0100, 4'b0000, 3'b000, 2'b00, 4'h0, 8'h00, 2'b00, 8'h00, 8'h00, 4'h2, 4'h1, 16'h0000, 1'b0));
        // collision of read with new frame
        vecs.push_back(mk(4'b0001, 4'b1100, 3'b000, 2'b00, 4'h0, 8'h11, 2'b00, 8'h11, 8'h64, 4'h3, 4'h1, 16'h0002, 1'b1));
        vecs.push_back(mk(4'b0101, 4'b0010, 3'b000, 2'b00, 4'h0, 8'h3C, 2'b00, 8'h3C, 8'h14, 4'h3, 4'h1, 16'h0002, 1'b1));
        vecs.push_back(mk(4'b0100, 4'b0000, 3'b000, 2'b00, 4'h0, 8'h00, 2'b00, 8'h3C, 8'h00, 4'h2, 4'h1, 16'h0000, 1'b0));
        // busy
        vecs.push_back(mk(4'b0000, 4'b0000, 3'b000, 2'b00, 4'h0, 8'h00, 2'b10, 8'h3C, 8'h01, 4'h2, 4'h1, 16'h0000, 1'b0));
        vecs.push_back(mk(4'b0000, 4'b0000, 3'b000, 2'b00, 4'h0, 8'h00, 2'b01, 8'h3C, 8'h01, 4'h2, 4'h1, 16'h0000, 1'b0));
        // IV drain
        vecs.push_back(mk(4'b0000, 4'b0000, 3'b000, 2'b01, 4'hF, 8'h00, 2'b00, 8'h3C, 8'h00, 4'h2, 4'hF, 16'h0004, 1'b1));
        vecs.push_back(mk(4'b0000, 4'b0000, 3'b000, 2'b10, 4'hF, 8'h00, 2'b00, 8'h3C, 8'h00, 4'hF, 4'hF, 16'h0002, 1'b1));
        vecs.push_back(mk(4'b0010, 4'b0000, 3'b000, 2'b00, 4'h0, 8'h00, 2'b00, 8'h3C, 8'h00, 4'hE, 4'hF, 16'h0004, 1'b1));
        vecs.push_back(mk(4'b0010, 4'b0000, 3'b000, 2'b00, 4'h0, 8'h00, 2'b00, 8'h3C, 8'h00, 4'hC, 4'hF, 16'h0006, 1'b1));
        vecs.push_back(mk(4'b0010, 4'b0000, 3'b000, 2'b00, 4'h0, 8'h00, 2'b00, 8'h3C, 8'h00, 4'h8, 4'hF, 16'h0008, 1'b1));
        vecs.push_back(mk(4'b0010, 4'b0000, 3'b000, 2'b00, 4'h0, 8'h00, 2'b00, 8'h3C, 8'h00, 4'h0, 4'hF, 16'h0000, 1'b0));
        vecs.push_back(mk(4'b0010, 4'b0000, 3'b000, 2'b00, 4'h0, 8'h00, 2'b00, 8'h3C, 8'h00, 4'h0, 4'hF, 16'h0000, 1'b0));
        // set wins over rdIV clear; write wins over clear; set wins over write
        vecs.push_back(mk(4'b0000, 4'b0000, 3'b000, 2'b10, 4'h2, 8'h00, 2'b00, 8'h3C, 8'h00, 4'h2, 4'hF, 16'h0004, 1'b1));
        vecs.push_back(mk(4'b0010, 4'b0000, 3'b001, 2'b00, 4'h0, 8'h00, 2'b00, 8'h3C, 8'h00, 4'h2, 4'hF, 16'h0004, 1'b1));
        vecs.push_back(mk(4'b0010, 4'b0000, 3'b000, 2'b00, 4'h0, 8'h00, 2'b00, 8'h3C, 8'h00, 4'h0, 4'hF, 16'h0000, 1'b0));
        vecs.push_back(mk(4'b0000, 4'b0000, 3'b010, 2'b10, 4'h0, 8'h00, 2'b00, 8'h3C, 8'h00, 4'h4, 4'hF, 16'h0006, 1'b1));
        vecs.push_back(mk(4'b0010, 4'b0000, 3'b000, 2'b10, 4'h1, 8'h00, 2'b00, 8'h3C, 8'h00, 4'h1, 4'hF, 16'h0002, 1'b1));
        // software reset
        vecs.push_back(mk(4'b0001, 4'b1111, 3'b000, 2'b10, 4'hF, 8'h55, 2'b00, 8'h55, 8'h7C, 4'hF, 4'hF, 16'h0002, 1'b1));
        vecs.push_back(mk(4'b1001, 4'b1111, 3'b100, 2'b00, 4'h0, 8'hAA, 2'b00, 8'h55, 8'h00, 4'h2, 4'hF, 16'h0004, 1'b1));
        vecs.push_back(mk(4'b1100, 4'b0000, 3'b000, 2'b10, 4'hF, 8'h00, 2'b00, 8'h55, 8'h00, 4'h2, 4'hF, 16'h0004, 1'b1));
        vecs.push_back(mk(4'b0000, 4'b0000, 3'b000, 2'b00, 4'h0, 8'h00, 2'b00, 8'h55, 8'h00, 4'h2, 4'hF, 16'h0004, 1'b1));
        vecs.push_back(mk(4'b0010, 4'b0000, 3'b000, 2'b00, 4'h0, 8'h00, 2'b00, 8'h55, 8'h00, 4'h0, 4'hF, 16'h0000, 1'b0));

        // Reset state
        idle();
        reset = 1'b1;
        repeat (2) @(negedge MCLK);
        compare("reset", mk(4'b0, 4'b0, 3'b0, 2'b0, 4'h0, 8'h00, 2'b0,
                            8'h00, 8'h00, 4'h2, 4'h0, 16'h0000, 1'b0));
        reset = 1'b0;

        // Table vectors through the scoreboard
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge MCLK);
            drive(vecs[i]);
            sb.push_back(vecs[i]);
            @(posedge MCLK);
            #1;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL v%0d scoreboard: got empty expected entry", i);
            end else begin
                v = sb.pop_front();
                compare($sformatf("v%0d", i), v);
            end
        end

        // Asynchronous reset mid-frame: values return at once, strobes lost
        @(negedge MCLK);
        idle();
        rSetRxIFG = 1'b1; RxData = 8'h99; wrIE = 1'b1; wData = 4'hF;
        #2 reset = 1'b1;
        #1;
        check("async RXBUF", 16'(RXBUF), 16'h0000);
        check("async IFG",   16'(IFG),   16'h0002);
        check("async IE",    16'(IE),    16'h0000);
        check("async IV",    IV,         16'h0000);
        @(posedge MCLK);
        #1;
        @(negedge MCLK);
        idle();
        reset = 1'b0;
        @(posedge MCLK);
        #1;
        check("post RXBUF", 16'(RXBUF), 16'h0000);
        check("post IFG",   16'(IFG),   16'h0002);
        check("post IE",    16'(IE),    16'h0000);
        check("post IRQ",   16'(IRQ),   16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
